systolic_skew_feeder: RTL and testbench

Input staging stage that sits directly upstream of the tpumac systolic array and drives its left-edge A inputs. It holds a DIM x DIM tile of signed BITS_AB operands loaded one row per write. On command it streams the tile out diagonally skewed: row i is delayed by i cycles, so operands meet the correct B/C wavefront in the array. It also produces the enable that steps the array's MAC cells.

---
 rtl/systolic_skew_feeder.sv | 92 +++++++++
 tb/tb_systolic_skew_feeder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Operand staging for the systolic array's left edge.
// Holds a DIM x DIM tile and streams it out diagonally skewed.
module systolic_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       WrEn,
  input  logic [$clog2(DIM)-1:0]     WrRow,
  input  logic [DIM*BITS_AB-1:0]     Arow,
  input  logic                       start,
  input  logic                       stall,
  output logic [DIM*BITS_AB-1:0]     Aout,
  output logic                       en_out,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_err
);

  localparam int CW   = $clog2(2*DIM-1);
  localparam int LAST = 2*DIM-2;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BITS_AB-1:0]   tile [DIM][DIM];
  logic [DIM*BITS_AB-1:0] beat;
  logic                 wr_ok;
  logic                 last;

  assign busy  = (state == STREAM);
  assign last  = (cnt == CW'(LAST));
  assign wr_ok = WrEn && (int'(WrRow) < DIM);

  // Row i sees column t-i; anything outside the window is zero.
  always_comb begin
    beat = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int c = 0; c < DIM; c++) begin
        if (int'(cnt) == i + c)
          beat[i*BITS_AB +: BITS_AB] = tile[i][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      Aout   <= '0;
      en_out <= 1'b0;
      done   <= 1'b0;
      wr_err <= 1'b0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          tile[r][c] <= '0;
    end else begin
      wr_err <= (state == STREAM) && WrEn;
      unique case (state)
        IDLE: begin
          Aout   <= '0;
          en_out <= 1'b0;
          done   <= 1'b0;
          if (wr_ok)
            for (int c = 0; c < DIM; c++)
              tile[WrRow][c] <= Arow[c*BITS_AB +: BITS_AB];
          if (start) begin
            cnt   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (stall) begin
            en_out <= 1'b0;
            done   <= 1'b0;
          end else begin
            Aout   <= beat;
            en_out <= 1'b1;
            cnt    <= cnt + CW'(1);
            done   <= last;
            if (last)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed passes plus random traffic
// checked every cycle against a pass-level model.
module tb_systolic_skew_feeder;

  localparam int B = 8;
  localparam int D = 4;
  localparam int NB = 2*D-1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         WrEn = 1'b0;
  logic [1:0]   WrRow = '0;
  logic [D*B-1:0] Arow = '0;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic [D*B-1:0] Aout;
  logic         en_out, busy, done, wr_err;

  int checks = 0;
  int errors = 0;

  systolic_skew_feeder #(.BITS_AB(B), .DIM(D)) dut (
    .clk(clk), .rst_n(rst_n), .WrEn(WrEn), .WrRow(WrRow), .Arow(Arow),
    .start(start), .stall(stall), .Aout(Aout), .en_out(en_out),
    .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a pass is beat index t; beat t puts tile[i][t-i] on row i.
  logic [B-1:0]   m_tile [D][D];
  logic [D*B-1:0] m_aout = '0;
  logic           m_en = 1'b0, m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  int             m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < D; r++)
        for (int c = 0; c < D; c++)
          m_tile[r][c] <= '0;
      m_aout <= '0; m_en <= 1'b0; m_done <= 1'b0;
      m_err <= 1'b0; m_busy <= 1'b0; m_t <= 0;
    end else begin
      m_err <= m_busy && WrEn;
      if (!m_busy) begin
        if (WrEn)
          for (int c = 0; c < D; c++)
            m_tile[WrRow][c] <= Arow[c*B +: B];
        m_aout <= '0; m_en <= 1'b0; m_done <= 1'b0;
        if (start) begin
          m_busy <= 1'b1;
          m_t <= 0;
        end
      end else if (stall) begin
        m_en <= 1'b0; m_done <= 1'b0;
      end else begin
        for (int i = 0; i < D; i++)
          m_aout[i*B +: B] <= (m_t >= i && m_t - i < D) ?
                              m_tile[i][(m_t-i) % D] : '0;
        m_en <= 1'b1;
        m_done <= (m_t == NB-1);
        if (m_t == NB-1) m_busy <= 1'b0;
        m_t <= m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("aout", 64'(Aout), 64'(m_aout));
    chk("en_out", 64'(en_out), 64'(m_en));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("wr_err", 64'(wr_err), 64'(m_err));
  end

  task automatic write_row(input int r, input logic [D*B-1:0] d);
    @(negedge clk);
    WrEn = 1'b1; WrRow = 2'(r); Arow = d;
    @(negedge clk);
    WrEn = 1'b0;
  endtask

  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_pass(output int ens, output int dones);
    int n;
    ens = 0; dones = 0; n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      if (en_out) ens++;
      if (done) dones++;
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL pass_timeout: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  function automatic logic [B-1:0] row(input int i);
    return Aout[i*B +: B];
  endfunction

  int r0 [NB] = '{0, 1, 2, 3, 0, 0, 0};
  int r1 [NB] = '{0, 16, 17, 18, 19, 0, 0};
  int r3 [NB] = '{0, 0, 0, 48, 49, 50, 51};
  int sg [NB] = '{0, 0, 'h80, 'h7f, 'hff, 0, 0};

  initial begin
    logic [D*B-1:0] d;
    int ens, dones;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_aout", 64'(Aout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    #2 rst_n = 1'b1;

    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) d[c*B +: B] = B'(16*r + c);
      write_row(r, d);
    end
    start_pass();
    ens = 0;
    for (int t = 0; t < NB; t++) begin
      @(negedge clk);
      chk($sformatf("lit_r0_t%0d", t), 64'(row(0)), 64'(r0[t]));
      chk($sformatf("lit_r1_t%0d", t), 64'(row(1)), 64'(r1[t]));
      chk($sformatf("lit_r3_t%0d", t), 64'(row(3)), 64'(r3[t]));
      chk($sformatf("lit_done_t%0d", t), 64'(done), 64'(t == NB-1));
      if (en_out) ens++;
    end
    chk("lit_en_count", 64'(ens), 64'd7);
    @(negedge clk);
    chk("lit_post_en", 64'(en_out), 64'd0);

    d = {8'h00, 8'hff, 8'h7f, 8'h80};
    write_row(2, d);
    start_pass();
    for (int t = 0; t < NB; t++) begin
      @(negedge clk);
      chk($sformatf("lit_sgn_t%0d", t), 64'(row(2)), 64'(sg[t]));
    end

    start_pass();
    repeat (3) @(negedge clk);
    chk("lit_stall_b2", 64'(row(1)), 64'd17);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_stall_hold", 64'(row(1)), 64'd17);
    chk("lit_stall_en", 64'(en_out), 64'd0);
    stall = 1'b0;
    finish_pass(ens, dones);
    chk("lit_stall_ens", 64'(ens), 64'd4);
    chk("lit_stall_dones", 64'(dones), 64'd1);

    start_pass();
    repeat (4) @(negedge clk);
    WrEn = 1'b1; WrRow = 2'd1; Arow = '1;
    @(negedge clk);
    WrEn = 1'b0;
    chk("lit_wr_err", 64'(wr_err), 64'd1);
    @(negedge clk);
    chk("lit_wr_err_pulse", 64'(wr_err), 64'd0);
    finish_pass(ens, dones);
    start_pass();
    repeat (3) @(negedge clk);
    chk("lit_old_row1", 64'(row(1)), 64'd17);
    finish_pass(ens, dones);

    @(negedge clk);
    start = 1'b1; WrEn = 1'b1; WrRow = 2'd0; Arow = {4{8'd9}};
    @(negedge clk);
    start = 1'b0; WrEn = 1'b0;
    @(negedge clk);
    chk("lit_simul_r0", 64'(row(0)), 64'd9);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_aout", 64'(Aout), 64'd0);
    chk("lit_rst_en", 64'(en_out), 64'd0);
    chk("lit_rst_busy", 64'(busy), 64'd0);
    chk("lit_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    start_pass();
    ens = 0;
    for (int t = 0; t < NB; t++) begin
      @(negedge clk);
      chk($sformatf("lit_zero_t%0d", t), 64'(Aout), 64'd0);
      chk($sformatf("lit_zdone_t%0d", t), 64'(done), 64'(t == NB-1));
      if (en_out) ens++;
    end
    chk("lit_zero_ens", 64'(ens), 64'd7);

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      WrEn  = ($urandom_range(0, 3) == 0);
      WrRow = 2'($urandom_range(0, 3));
      Arow  = $urandom;
      start = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 4) == 0);
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    WrEn = 1'b0; start = 1'b0; stall = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
